// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch redirect controller.
package fetch_pkg;

  // Major opcodes of the control-transfer instructions resolved at X.
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Prediction made at fetch, carried alongside the instruction to X.
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } pred_meta_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } redir_state_e;

  // An empty pipeline slot.
  localparam pred_meta_t META_BUBBLE = '{valid: 1'b0, taken: 1'b0, target: 32'h0};

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: advance on an event unless already saturated.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: chooses the next PC from prediction, PC+4 or an X-stage
// correction, tracks the fetch-time prediction down to X and flushes the
// wrong path on a mispredict.
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             pred_hit_i,
  input  logic [31:0]      pred_target_i,
  input  logic             x_is_ctrl_i,
  input  logic             x_taken_i,
  input  logic [31:0]      x_target_i,
  input  logic [31:0]      x_pc_i,
  output logic [31:0]      pc_F_o,
  output logic             redirect_o,
  output logic             flush_D_o,
  output logic             flush_X_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [0:0] ST_RUN   = RUN;
  localparam logic [0:0] ST_FLUSH = FLUSH;

  // The flush counter only ever holds FLUSH_CYC-1 down to 0.
  localparam int unsigned     FC_W    = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);

  // A zero-length flush window would make the counter load wrap.
  if (FLUSH_CYC == 0) begin : g_bad_flush_cyc
    $error("fetch_redirect_ctrl: FLUSH_CYC must be at least 1");
  end

  logic [31:0]     pc_q,     pc_d;
  pred_meta_t      slot_d_q, slot_d_d;
  pred_meta_t      slot_x_q, slot_x_d;
  logic [0:0]      state_q,  state_d;
  logic [FC_W-1:0] fcnt_q,   fcnt_d;

  pred_meta_t  fetch_meta;
  logic        x_resolve;
  logic        mispredict;
  logic [31:0] correct_pc;

  assign fetch_meta = '{valid: 1'b1, taken: pred_hit_i, target: pred_target_i};

  // A real control transfer reaches X outside the wrong-path window.
  assign x_resolve  = (state_q == ST_RUN) && x_is_ctrl_i && slot_x_q.valid;

  // Wrong direction, or right direction (taken) with the wrong target.
  // A taken JALR was never predicted taken, so it always lands here.
  assign mispredict = x_resolve &&
                      ((x_taken_i != slot_x_q.taken) ||
                       (x_taken_i && (x_target_i != slot_x_q.target)));

  assign correct_pc = x_taken_i ? x_target_i : (x_pc_i + 32'd4);

  // Next PC and metadata slots: redirect beats stall beats prediction.
  always_comb begin
    pc_d     = pc_q;
    slot_d_d = slot_d_q;
    slot_x_d = slot_x_q;
    if (mispredict) begin
      pc_d     = correct_pc;
      slot_d_d = META_BUBBLE;
      slot_x_d = META_BUBBLE;
    end else if (stall_i) begin
      slot_x_d = META_BUBBLE;
    end else begin
      pc_d     = pred_hit_i ? pred_target_i : (pc_q + 32'd4);
      slot_d_d = fetch_meta;
      slot_x_d = slot_d_q;
    end
  end

  // Redirect FSM: after a redirect, ignore X for the wrong-path bubbles.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_LOAD;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // PC, metadata and FSM registers.
  always_ff @(posedge clk_i) begin
    // NOTE: the slots are reset as well as the PC, so a stale valid bit can never fake a resolution.
    if (!rst_ni) begin
      pc_q     <= RESET_PC;
      slot_d_q <= META_BUBBLE;
      slot_x_q <= META_BUBBLE;
      state_q  <= ST_RUN;
      fcnt_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      slot_d_q <= slot_d_d;
      slot_x_q <= slot_x_d;
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (x_resolve),
    .cnt_o  (br_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (mispredict),
    .cnt_o  (mispred_cnt_o)
  );

  assign pc_F_o     = pc_q;
  assign redirect_o = mispredict;
  assign flush_D_o  = mispredict;
  assign flush_X_o  = mispredict;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl. Each stimulus cycle queues the
// hand-computed outputs for that cycle; a monitor pops and compares them.
module tb_fetch_redirect_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             stall_i;
  logic             pred_hit_i;
  logic [31:0]      pred_target_i;
  logic             x_is_ctrl_i;
  logic             x_taken_i;
  logic [31:0]      x_target_i;
  logic [31:0]      x_pc_i;
  logic [31:0]      pc_F_o;
  logic             redirect_o;
  logic             flush_D_o;
  logic             flush_X_o;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        redir;
    logic [3:0]  br;
    logic [3:0]  mis;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_steps = 0;

  fetch_redirect_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .FLUSH_CYC (2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .stall_i       (stall_i),
    .pred_hit_i    (pred_hit_i),
    .pred_target_i (pred_target_i),
    .x_is_ctrl_i   (x_is_ctrl_i),
    .x_taken_i     (x_taken_i),
    .x_target_i    (x_target_i),
    .x_pc_i        (x_pc_i),
    .pc_F_o        (pc_F_o),
    .redirect_o    (redirect_o),
    .flush_D_o     (flush_D_o),
    .flush_X_o     (flush_X_o),
    .br_cnt_o      (br_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare them on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pc_F",        e.idx, pc_F_o,        e.pc);
      check("redirect",    e.idx, 32'(redirect_o), 32'(e.redir));
      check("flush_D",     e.idx, 32'(flush_D_o),  32'(e.redir));
      check("flush_X",     e.idx, 32'(flush_X_o),  32'(e.redir));
      check("br_cnt",      e.idx, 32'(br_cnt_o),   32'(e.br));
      check("mispred_cnt", e.idx, 32'(mispred_cnt_o), 32'(e.mis));
    end
  end

  // One cycle: drive inputs just after the edge, queue what this cycle must show.
  task automatic step(input logic stall, input logic hit, input logic [31:0] tgt,
                      input logic xc, input logic xt, input logic [31:0] xtg,
                      input logic [31:0] xpc,
                      input logic [31:0] e_pc, input logic e_r,
                      input logic [3:0] e_br, input logic [3:0] e_mis);
    exp_t e;
    stall_i       = stall;
    pred_hit_i    = hit;
    pred_target_i = tgt;
    x_is_ctrl_i   = xc;
    x_taken_i     = xt;
    x_target_i    = xtg;
    x_pc_i        = xpc;
    e.idx   = n_steps;
    e.pc    = e_pc;
    e.redir = e_r;
    e.br    = e_br;
    e.mis   = e_mis;
    sb.push_back(e);
    n_steps++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] e_pc, input logic [3:0] e_br, input logic [3:0] e_mis);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, e_pc, 1'b0, e_br, e_mis);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d steps issued", n_steps);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p;
    logic [31:0] nxt;
    logic [3:0]  eb;
    logic [3:0]  em;

    rst_ni = 1'b0;
    stall_i = 1'b0; pred_hit_i = 1'b0; pred_target_i = '0;
    x_is_ctrl_i = 1'b0; x_taken_i = 1'b0; x_target_i = '0; x_pc_i = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held: even a resolving X instruction cannot raise flags.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h5, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
    rst_ni = 1'b1;

    // Sequential fetch.
    idle(32'h00, 4'd0, 4'd0);
    idle(32'h04, 4'd0, 4'd0);
    idle(32'h08, 4'd0, 4'd0);
    idle(32'h0C, 4'd0, 4'd0);
    // Predicted taken at 0x10 -> 0x100, confirmed correct at X two cycles later.
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,  32'h010, 1'b0, 4'd0, 4'd0);
    idle(32'h100, 4'd0, 4'd0);
    step(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'h10, 32'h104, 1'b0, 4'd0, 4'd0);
    // Jump to 0x20 through a prediction.
    step(1'b0, 1'b1, 32'h20,  1'b0, 1'b0, 32'h0,   32'h0,  32'h108, 1'b0, 4'd1, 4'd0);
    idle(32'h20, 4'd1, 4'd0);
    idle(32'h24, 4'd1, 4'd0);
    // 0x20 fetched not-taken, resolves taken to 0x80.
    step(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h80,  32'h20, 32'h028, 1'b1, 4'd1, 4'd0);
    // Two flush cycles: resolutions ignored. Fetch predicts 0x200 twice.
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h999, 32'h0,  32'h080, 1'b0, 4'd2, 4'd1);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h999, 32'h0,  32'h200, 1'b0, 4'd2, 4'd1);
    // Predicted taken to 0x200, resolved not-taken at x_pc 0x40 -> 0x44.
    step(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h40, 32'h200, 1'b1, 4'd2, 4'd1);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   32'h0,  32'h044, 1'b0, 4'd3, 4'd2);
    idle(32'h200, 4'd3, 4'd2);
    // Predicted taken to 0x200, resolved taken to 0x300.
    step(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 32'h44, 32'h204, 1'b1, 4'd3, 4'd2);
    step(1'b0, 1'b1, 32'h50,  1'b0, 1'b0, 32'h0,   32'h0,  32'h300, 1'b0, 4'd4, 4'd3);
    // Stall at 0x50: PC holds and X becomes a bubble, so a mismatch is harmless.
    step(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,  32'h050, 1'b0, 4'd4, 4'd3);
    step(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,  32'h050, 1'b0, 4'd4, 4'd3);
    idle(32'h50, 4'd4, 4'd3);
    // Mispredict under stall (wrong target) still redirects to 0x60.
    step(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h60,  32'h300, 32'h054, 1'b1, 4'd4, 4'd3);

    // Back-to-back mispredicts drive both 4-bit counters into saturation.
    p = 32'h60; eb = 4'd5; em = 4'd4;
    for (int k = 0; k < 12; k++) begin
      nxt = 32'h1000 + 32'(k) * 32'h100;
      idle(p,          eb, em);
      idle(p + 32'd4,  eb, em);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, nxt, p, p + 32'd8, 1'b1, eb, em);
      if (eb != 4'hF) eb++;
      if (em != 4'hF) em++;
      p = nxt;
    end

    // Counters stuck at all-ones; reset lands in the first flush cycle.
    rst_ni = 1'b0;
    idle(p, 4'hF, 4'hF);
    rst_ni = 1'b1;
    // From RESET_PC: predict to 0xFFFFFFFC, sequential wraps to 0,
    // then a not-taken resolution at 0xFFFFFFFC corrects to 0 (wrap).
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
    idle(32'hFFFF_FFFC, 4'd0, 4'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 4'd0, 4'd0);
    idle(32'h0, 4'd1, 4'd1);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
